// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: load-use / MDU / branch / memory-hold stall sequencer for a 5-stage MIPS32 pipeline
module pipeline_stall_controller #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          id_instruction,
    input  logic [31:0]          ex_instruction,
    input  logic                 branch_taken,
    input  logic                 mdu_busy,
    input  logic                 mem_hold,
    output logic                 pc_write_en,
    output logic                 if_id_write_en,
    output logic                 if_id_flush,
    output logic                 id_ex_write_en,
    output logic                 id_ex_bubble,
    output logic                 stall_active,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic                 mdu_timeout
);
    localparam int WAIT_W = $clog2(MDU_TIMEOUT + 1);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic [5:0]        id_op, ex_op, funct;
    logic [4:0]        id_rs, id_rt, ex_rt;
    logic              reads_rs, reads_rt, load_use, mdu_op, mdu_cond, mdu_stall, hazard;

    assign id_op = id_instruction[31:26];
    assign id_rs = id_instruction[25:21];
    assign id_rt = id_instruction[20:16];
    assign funct = id_instruction[5:0];
    assign ex_op = ex_instruction[31:26];
    assign ex_rt = ex_instruction[20:16];

    assign reads_rs = !(id_op == 6'b000010 || id_op == 6'b000011 || id_instruction == 32'h0);
    assign reads_rt = id_op == 6'b000000 || id_op == 6'b101011 || id_op == 6'b000100 || id_op == 6'b000101;
    assign load_use = ex_op == 6'b100011 && ex_rt != 5'd0 &&
                      ((reads_rs && ex_rt == id_rs) || (reads_rt && ex_rt == id_rt));
    assign mdu_op   = id_op == 6'b000000 &&
                      (funct == 6'b010000 || funct == 6'b010010 || funct == 6'b011000 ||
                       funct == 6'b011001 || funct == 6'b011010 || funct == 6'b011011);
    // once waiting, only a falling mdu_busy (or a branch) lets the held instruction issue
    assign mdu_cond  = (mdu_op && mdu_busy) || (state == MDU_WAIT && mdu_busy);
    assign hazard    = !branch_taken && (load_use || mdu_cond);
    assign mdu_stall = !branch_taken && !load_use && mdu_cond;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            mdu_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            wait_cnt     <= wait_next;
            stall_cycles <= (stall_active && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
            mdu_timeout  <= mdu_timeout || wait_next == WAIT_W'(MDU_TIMEOUT);
        end
    end

    always_comb begin
        state_next = mem_hold ? state : mdu_stall ? MDU_WAIT : RUN;
        wait_next  = mem_hold ? wait_cnt :
                     !mdu_stall ? '0 :
                     wait_cnt == WAIT_W'(MDU_TIMEOUT) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_comb begin
        pc_write_en    = reset_n && !mem_hold && !hazard;
        if_id_write_en = reset_n && !mem_hold && !hazard;
        id_ex_write_en = !reset_n || !mem_hold;
        if_id_flush    = !reset_n || (!mem_hold && branch_taken);
        id_ex_bubble   = !reset_n || (!mem_hold && (branch_taken || hazard));
        stall_active   = reset_n && (mem_hold || hazard);
    end
endmodule
